// File: rtl/lk_pkg.sv
// Shared constants and types for the Lucas-Kanade flow path.
package lk_pkg;

    localparam int LK_FRAC = 8;
    localparam int ACC_W   = 32;
    localparam int PROD_W  = 64;

    typedef enum logic [1:0] {IDLE, PROD, COMB, DIV} state_t;

    typedef logic signed [15:0] q8_8_t;

endpackage

// File: rtl/lk_flow_div.sv
// Unsigned restoring divider, one quotient bit per step; quotient replaces the dividend in place.
module lk_flow_div #(
    parameter int DW = 72,
    parameter int VW = 64
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          load,
    input  logic          step,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quo_next,
    output logic          ready
);

    localparam int CW = $clog2(DW + 1);

    logic [DW-1:0] dvd;
    logic [VW-1:0] rem;
    logic [CW-1:0] count;
    logic [VW:0]   rem_shift;
    logic [VW-1:0] diff;
    logic          ge;

    // Modular VW-bit subtraction is exact whenever ge holds, since the result is below divisor.
    always_comb begin
        rem_shift = {rem, dvd[DW-1]};
        ge        = (rem_shift >= {1'b0, divisor});
        diff      = rem_shift[VW-1:0] - divisor;
        quo_next  = {dvd[DW-2:0], ge};
    end

    // ready marks the step that completes the quotient, so quo_next is final in that cycle.
    assign ready = (count == CW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dvd   <= '0;
            rem   <= '0;
            count <= '0;
        end else if (load) begin
            dvd   <= dividend;
            rem   <= '0;
            count <= CW'(DW);
        end else if (step && count != '0) begin
            dvd   <= quo_next;
            rem   <= ge ? diff : rem_shift[VW-1:0];
            count <= count - CW'(1);
        end
    end

endmodule

// File: rtl/lk_flow_solver.sv
// Solves the 2x2 structure-tensor system per window and emits the Q8.8 flow increment.
module lk_flow_solver
    import lk_pkg::*;
#(
    parameter int FRAC    = LK_FRAC,
    parameter int OW      = 16,
    parameter int DET_MIN = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic signed [ACC_W-1:0] ir2,
    input  logic signed [ACC_W-1:0] ic2,
    input  logic signed [ACC_W-1:0] iric,
    input  logic signed [ACC_W-1:0] er,
    input  logic signed [ACC_W-1:0] ec,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    done,
    output logic signed [OW-1:0]    dr,
    output logic signed [OW-1:0]    dc,
    output logic                    singular,
    output logic                    sat,
    output logic                    overrun
);

    localparam int ND = PROD_W + FRAC;
    localparam logic [ND-1:0] MAXV = ND'((64'd1 << (OW - 1)) - 64'd1);

    state_t state, state_next;

    logic signed [ACC_W-1:0]  ir2_q, ic2_q, iric_q, er_q, ec_q;
    logic signed [PROD_W-1:0] p_ir2ic2, p_iric2, p_ic2er, p_iricec, p_ir2ec, p_iricer;
    logic signed [PROD_W:0]   det, nr, nc;
    logic [PROD_W-1:0]        det_abs, nr_abs, nc_abs, det_mag;
    logic                     neg_r, neg_c, singular_now;
    logic                     div_load, div_step, rdy_r, rdy_c, div_last;
    logic [ND-1:0]            quo_r, quo_c;
    logic [OW:0]              res_r, res_c;

    function automatic logic [PROD_W-1:0] mag(input logic signed [PROD_W:0] v);
        mag = v[PROD_W] ? PROD_W'(-v) : v[PROD_W-1:0];
    endfunction

    // Returns {saturated, signed result}; clamping is symmetric so -MAXV is the floor.
    function automatic logic [OW:0] sign_sat(input logic [ND-1:0] m, input logic neg);
        logic          s;
        logic [ND-1:0] c;
        s = (m > MAXV);
        c = s ? MAXV : m;
        sign_sat = {s, neg ? -c[OW-1:0] : c[OW-1:0]};
    endfunction

    assign det = {p_ir2ic2[PROD_W-1], p_ir2ic2} - {p_iric2[PROD_W-1], p_iric2};
    assign nr  = {p_ic2er[PROD_W-1], p_ic2er}   - {p_iricec[PROD_W-1], p_iricec};
    assign nc  = {p_ir2ec[PROD_W-1], p_ir2ec}   - {p_iricer[PROD_W-1], p_iricer};

    assign det_abs      = mag(det);
    assign nr_abs       = mag(nr);
    assign nc_abs       = mag(nc);
    assign singular_now = (det_abs < PROD_W'(DET_MIN));
    assign div_load     = (state == COMB) && !singular_now;
    assign div_step     = (state == DIV);
    assign div_last     = rdy_r & rdy_c;
    assign res_r        = sign_sat(quo_r, neg_r);
    assign res_c        = sign_sat(quo_c, neg_c);

    lk_flow_div #(.DW(ND), .VW(PROD_W)) u_div_r (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (div_load),
        .step     (div_step),
        .dividend ({nr_abs, {FRAC{1'b0}}}),
        .divisor  (det_mag),
        .quo_next (quo_r),
        .ready    (rdy_r)
    );

    lk_flow_div #(.DW(ND), .VW(PROD_W)) u_div_c (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (div_load),
        .step     (div_step),
        .dividend ({nc_abs, {FRAC{1'b0}}}),
        .divisor  (det_mag),
        .quo_next (quo_c),
        .ready    (rdy_c)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PROD;
            PROD:    state_next = COMB;
            COMB:    state_next = singular_now ? IDLE : DIV;
            DIV:     if (div_last) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath and registered outputs; the divisor register is shared by both dividers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            {ir2_q, ic2_q, iric_q, er_q, ec_q} <= '0;
            {p_ir2ic2, p_iric2, p_ic2er, p_iricec, p_ir2ec, p_iricer} <= '0;
            det_mag  <= '0;
            neg_r    <= 1'b0;
            neg_c    <= 1'b0;
            acc_clr  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dr       <= '0;
            dc       <= '0;
            singular <= 1'b0;
            sat      <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            acc_clr <= 1'b0;
            done    <= 1'b0;
            if (start && busy) overrun <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    ir2_q   <= ir2;
                    ic2_q   <= ic2;
                    iric_q  <= iric;
                    er_q    <= er;
                    ec_q    <= ec;
                    busy    <= 1'b1;
                    acc_clr <= 1'b1;
                end
                PROD: begin
                    p_ir2ic2 <= PROD_W'(ir2_q)  * PROD_W'(ic2_q);
                    p_iric2  <= PROD_W'(iric_q) * PROD_W'(iric_q);
                    p_ic2er  <= PROD_W'(ic2_q)  * PROD_W'(er_q);
                    p_iricec <= PROD_W'(iric_q) * PROD_W'(ec_q);
                    p_ir2ec  <= PROD_W'(ir2_q)  * PROD_W'(ec_q);
                    p_iricer <= PROD_W'(iric_q) * PROD_W'(er_q);
                end
                COMB: begin
                    if (singular_now) begin
                        dr       <= '0;
                        dc       <= '0;
                        singular <= 1'b1;
                        sat      <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        det_mag <= det_abs;
                        neg_r   <= nr[PROD_W] ^ det[PROD_W];
                        neg_c   <= nc[PROD_W] ^ det[PROD_W];
                    end
                end
                DIV: if (div_last) begin
                    dr       <= res_r[OW-1:0];
                    dc       <= res_c[OW-1:0];
                    sat      <= res_r[OW] | res_c[OW];
                    singular <= 1'b0;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lk_flow_solver.sv
// Self-checking bench for lk_flow_solver: vector table, model-driven random windows, and timing corner sequences.
module tb_lk_flow_solver;
    import lk_pkg::*;

    localparam int ND = PROD_W + LK_FRAC;

    logic               clk = 1'b0;
    logic               reset_n = 1'b0;
    logic               start = 1'b0;
    logic signed [31:0] ir2 = '0, ic2 = '0, iric = '0, er = '0, ec = '0;
    logic               acc_clr, busy, done, singular, sat, overrun;
    logic signed [15:0] dr, dc;

    typedef struct {
        int ir2, ic2, iric, er, ec;
        int edr, edc;
        bit esing, esat;
    } vec_t;

    typedef struct {
        int dr, dc;
        bit sing, sat;
        int t0;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   done_seen = 0;
    int   last_start = -100;

    lk_flow_solver dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .ir2      (ir2),
        .ic2      (ic2),
        .iric     (iric),
        .er       (er),
        .ec       (ec),
        .acc_clr  (acc_clr),
        .busy     (busy),
        .done     (done),
        .dr       (dr),
        .dc       (dc),
        .singular (singular),
        .sat      (sat),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic longint absl(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic vec_t model(input int a, input int b, input int c, input int d, input int f);
        vec_t   v;
        longint det, nr, nc, qr, qc;
        v = '{a, b, c, d, f, 0, 0, 1'b0, 1'b0};
        det = longint'(a) * b - longint'(c) * c;
        nr  = longint'(b) * d - longint'(c) * f;
        nc  = longint'(a) * f - longint'(c) * d;
        if (det == 0) begin
            v.esing = 1'b1;
        end else begin
            qr = (absl(nr) * 256) / absl(det);
            qc = (absl(nc) * 256) / absl(det);
            if (qr > 32767 || qc > 32767) v.esat = 1'b1;
            if (qr > 32767) qr = 32767;
            if (qc > 32767) qc = 32767;
            v.edr = int'(((nr < 0) != (det < 0)) ? -qr : qr);
            v.edc = int'(((nc < 0) != (det < 0)) ? -qc : qc);
        end
        return v;
    endfunction

    // Drives one start pulse; inputs are scrambled afterwards to prove only the accepted cycle is sampled.
    task automatic applyStimulus(input vec_t v, input bit expect_result);
        exp_t x;
        ir2  = v.ir2;
        ic2  = v.ic2;
        iric = v.iric;
        er   = v.er;
        ec   = v.ec;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        ir2  = $urandom;
        ic2  = $urandom;
        iric = $urandom;
        er   = $urandom;
        ec   = $urandom;
        if (expect_result) begin
            last_start = cyc;
            x = '{v.edr, v.edc, v.esing, v.esat, cyc};
            sb.push_back(x);
            checkOutput("busy_after_start", busy, 1);
        end
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checkOutput("result_timeout_pending", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic waitUntil(input int target);
        while (cyc < target) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_dr"}, dr, 0);
        checkOutput({tag, "_dc"}, dc, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_acc_clr"}, acc_clr, 0);
        checkOutput({tag, "_singular"}, singular, 0);
        checkOutput({tag, "_sat"}, sat, 0);
        checkOutput({tag, "_overrun"}, overrun, 0);
    endtask

    // Scoreboard consumer: every done pops one expectation, acc_clr must sit exactly one cycle after its start.
    always @(negedge clk) begin
        if (reset_n) begin
            if (done) begin
                done_seen++;
                if (sb.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    checkOutput("dr", dr, e.dr);
                    checkOutput("dc", dc, e.dc);
                    checkOutput("singular", singular, e.sing);
                    checkOutput("sat", sat, e.sat);
                    checkOutput("done_latency", cyc - e.t0 + 1, e.sing ? 3 : ND + 3);
                end
            end
            if (acc_clr) checkOutput("acc_clr_cycle", cyc - last_start + 1, 1);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   d0;

        tbl[0] = '{256,  256, 0,    512,  -256, 512,    -256,   1'b0, 1'b0};
        tbl[1] = '{512,  256, 128,  256,  0,    146,    -73,    1'b0, 1'b0};
        tbl[2] = '{256,  256, 256,  100,  100,  0,      0,      1'b1, 1'b0};
        tbl[3] = '{1,    1,   0,    1000, -1000, 32767, -32767, 1'b0, 1'b1};
        tbl[4] = '{1024, 512, -256, -300, 700,  14,     357,    1'b0, 1'b0};
        tbl[5] = '{100,  100, 200,  50,   -50,  -128,   128,    1'b0, 1'b0};
        tbl[6] = '{3,    12,  6,    77,   -5,   0,      0,      1'b1, 1'b0};
        tbl[7] = '{256,  256, 0,    0,    0,    0,      0,      1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1;
        checkResetValues("reset");
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i], 1'b1);
            waitIdle(200);
        end

        for (int i = 0; i < 6; i++) begin
            v = model(int'($urandom_range(4000, 1)), int'($urandom_range(4000, 1)),
                      int'($urandom_range(4000)) - 2000, int'($urandom_range(4000)) - 2000,
                      int'($urandom_range(4000)) - 2000);
            applyStimulus(v, 1'b1);
            waitIdle(200);
        end

        $display("[TB] back-to-back start while done is high");
        applyStimulus(tbl[2], 1'b1);
        repeat (2) @(posedge clk);
        #1;
        applyStimulus(tbl[0], 1'b1);
        waitIdle(200);
        checkOutput("overrun_after_back_to_back", overrun, 0);

        $display("[TB] second start during DIV");
        d0 = done_seen;
        applyStimulus(tbl[0], 1'b1);
        waitUntil(last_start + 9);
        applyStimulus(tbl[2], 1'b0);
        checkOutput("overrun_sticky_set", overrun, 1);
        waitIdle(200);
        repeat (10) @(posedge clk);
        #1;
        checkOutput("done_count_with_overrun", done_seen - d0, 1);
        checkOutput("overrun_still_set", overrun, 1);

        $display("[TB] reset abort mid-DIV");
        d0 = done_seen;
        applyStimulus(tbl[1], 1'b0);
        last_start = cyc;
        waitUntil(last_start + 39);
        reset_n = 1'b0;
        #1;
        checkResetValues("abort");
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        checkOutput("no_done_after_abort", done_seen - d0, 0);
        applyStimulus(tbl[1], 1'b1);
        waitIdle(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
